pc_gen: RTL and testbench
=========================

Name: pc_gen

Overview:
- Parametrised program-counter generator for the fetch stage.
- Replaces the fixed 32-bit, always-advancing PC.
- Adds:
  - configurable width, reset vector and step;
  - a valid/ready handshake towards instruction fetch, so the PC holds on a stall;
  - trap redirect;
  - a return-address stack (RAS) for call/return prediction.
- Sits between the branch/decode logic (redirect sources) and the instruction memory port (consumer of cur).

Parameters:
- XLEN, 32, width of PC and all address ports.
- RESET_VEC, 0, PC value loaded by reset.
- STEP, 4, sequential increment in bytes.
- RAS_DEPTH, 4, number of RAS entries (≥1).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-low.
- ready  in  1  fetch accepts cur this cycle.
- valid  out  1  cur is a valid fetch address.
- cur  out  XLEN  current PC.
- jmp  in  1  control-flow redirect request.
- rel  in  1  with jmp: target = cur + diff; else target = nxt.
- diff  in  XLEN  relative offset, two's complement.
- nxt  in  XLEN  absolute target.
- call  in  1  with jmp: push link (cur + STEP) onto the RAS.
- ret  in  1  with jmp: target = RAS top; pop.
- trap  in  1  exception redirect to tvec.
- tvec  in  XLEN  trap vector.
- ras_cnt  out  $clog2(RAS_DEPTH+1)  live RAS entries.
- ras_uflow  out  1  one-cycle pulse: ret issued on an empty RAS.

Behaviour:
- Reset (rst=0, asynchronous):
  - cur = RESET_VEC, valid = 0, ras_cnt = 0, ras_uflow = 0.
  - RAS contents are don't-care.
- First posedge after rst deasserts: valid becomes 1, cur stays RESET_VEC. valid then stays 1 until the next reset.
- Next-PC priority, evaluated each cycle with valid = 1:
  1. trap → cur <= tvec.
  2. jmp && ret → cur <= RAS top if ras_cnt > 0. If the RAS is empty: cur <= (rel ? cur + diff : nxt), and ras_uflow = 1 for the next cycle.
  3. jmp && !ret → cur <= rel ? cur + diff : nxt.
  4. ready → cur <= cur + STEP.
  5. Otherwise hold cur (stall).
- Redirects (cases 1–3) take effect regardless of ready. They flush the pending fetch.
- While valid = 0, all redirect inputs are ignored.
- Arithmetic: all additions are modulo 2^XLEN, so wrap-around is silent. diff is sign-agnostic (plain XLEN add). No alignment checking.
- RAS is a circular LIFO:
  - Push (jmp && call && !trap):
    - writes cur + STEP at the top and advances the top pointer;
    - ras_cnt saturates at RAS_DEPTH;
    - pushing when full overwrites the oldest entry.
  - Pop (jmp && ret && !trap && ras_cnt > 0):
    - reads the top and retreats the pointer;
    - ras_cnt decrements.
  - call && ret together (coroutine swap):
    - target = old top;
    - then the link is written into the same slot;
    - ras_cnt unchanged. If the RAS was empty: target uses the fallback path, link is pushed, ras_cnt = 1, ras_uflow pulses.
  - trap asserted: RAS and ras_cnt are unchanged, even if jmp/call/ret are also high.
  - call without jmp, or ret without jmp: ignored.
- Latency:
  - A redirect presented in cycle N appears on cur in cycle N+1.
  - ras_uflow is registered and high only in cycle N+1.
- Reset asserted mid-operation forces the reset values immediately, independent of clk.
- RAS_DEPTH = 1: behaves as a single link register. A push overwrites it; ras_cnt ∈ {0,1}.

Test Plan:
- Reset release, ready = 1, no redirects: cur = 0 until valid rises, then 0, 4, 8, 12. With XLEN = 32 and RESET_VEC = 32'hFFFF_FFF8: cur = FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Stall: ready = 0 for 3 cycles at cur = 0x10 → cur holds 0x10. jmp/rel with diff = 32'hFFFF_FFF0 during the stall → cur = 0x00 next cycle.
- Priority: trap = 1, tvec = 0x100, and jmp = 1, nxt = 0x200 in the same cycle → cur = 0x100, ras_cnt unchanged.
- RAS: call at cur = 0x40 (nxt = 0x80), call at 0x80 (nxt = 0xC0) → ras_cnt = 2. ret → cur = 0x84, then ret → cur = 0x44, ras_cnt = 0. A further ret with nxt = 0x300 → cur = 0x300, ras_uflow pulses once.
- RAS overflow with RAS_DEPTH = 4: 5 calls with links L1..L5 → ras_cnt = 4. Pops return L5, L4, L3, L2; a 5th pop underflows.
- Asynchronous reset asserted between clock edges while cur = 0x84 and ras_cnt = 2 → cur = RESET_VEC, valid = 0, ras_cnt = 0 immediately. After release, the first ret underflows.

Source files
------------

// File: rtl/pc_gen.sv
// pc_gen: fetch-stage program counter with valid/ready hold, trap/jump redirect
// and a circular return-address stack for call/return prediction.
module pc_gen #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter int              STEP      = 4,
    parameter int              RAS_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           ready,
    output logic                           valid,
    output logic [XLEN-1:0]                cur,
    input  logic                           jmp,
    input  logic                           rel,
    input  logic [XLEN-1:0]                diff,
    input  logic [XLEN-1:0]                nxt,
    input  logic                           call,
    input  logic                           ret,
    input  logic                           trap,
    input  logic [XLEN-1:0]                tvec,
    output logic [$clog2(RAS_DEPTH+1)-1:0] ras_cnt,
    output logic                           ras_uflow
);
    localparam int              CW     = $clog2(RAS_DEPTH + 1);
    localparam int              PW     = RAS_DEPTH > 1 ? $clog2(RAS_DEPTH) : 1;
    localparam logic [XLEN-1:0] STEP_X = XLEN'(STEP);

    logic [XLEN-1:0] ras [RAS_DEPTH];
    logic [PW-1:0]   ptr, ptr_inc, ptr_dec, ptr_n;
    logic [CW-1:0]   cnt_n;
    logic [XLEN-1:0] link, jtgt, cur_n;
    logic            act, push, pop, swap, empty_ret;

    // ptr names the next free slot; the top entry lives at ptr_dec
    always_comb begin
        ptr_inc   = ptr == PW'(RAS_DEPTH - 1) ? '0 : ptr + 1'b1;
        ptr_dec   = ptr == '0 ? PW'(RAS_DEPTH - 1) : ptr - 1'b1;
        link      = cur + STEP_X;
        jtgt      = rel ? cur + diff : nxt;
        act       = valid && jmp && !trap;
        push      = act && call;
        pop       = act && ret && ras_cnt != '0;
        swap      = push && pop;
        empty_ret = act && ret && ras_cnt == '0;
        cur_n     = !valid ? cur :
                    trap   ? tvec :
                    pop    ? ras[ptr_dec] :
                    jmp    ? jtgt :
                    ready  ? link : cur;
        ptr_n     = swap ? ptr : push ? ptr_inc : pop ? ptr_dec : ptr;
        cnt_n     = swap ? ras_cnt :
                    push ? (ras_cnt == CW'(RAS_DEPTH) ? ras_cnt : ras_cnt + 1'b1) :
                    pop  ? ras_cnt - 1'b1 : ras_cnt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid     <= 1'b0;
            cur       <= RESET_VEC;
            ptr       <= '0;
            ras_cnt   <= '0;
            ras_uflow <= 1'b0;
        end else begin
            valid     <= 1'b1;
            cur       <= cur_n;
            ptr       <= ptr_n;
            ras_cnt   <= cnt_n;
            ras_uflow <= empty_ret;
        end
    end

    // a swap overwrites the entry it just popped; a full push lands on the oldest slot
    always_ff @(posedge clk) begin
        if (push)
            ras[swap ? ptr_dec : ptr] <= link;
    end
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed vectors for pc_gen, plus a second instance with a
// reset vector near the top of the address space to cover wrap-around.
module tb_pc_gen;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ready = 1'b1, jmp = 1'b0, rel = 1'b0, call = 1'b0, ret = 1'b0, trap = 1'b0;
    logic [31:0] diff = '0, nxt = '0, tvec = '0;
    logic        valid, ras_uflow, valid2, uflow2;
    logic [31:0] cur, cur2;
    logic [2:0]  ras_cnt, cnt2;
    int          n_vec = 0, n_err = 0;

    pc_gen dut (
        .clk(clk), .rst(rst), .ready(ready), .valid(valid), .cur(cur),
        .jmp(jmp), .rel(rel), .diff(diff), .nxt(nxt), .call(call), .ret(ret),
        .trap(trap), .tvec(tvec), .ras_cnt(ras_cnt), .ras_uflow(ras_uflow)
    );

    pc_gen #(.RESET_VEC(32'hFFFF_FFF8)) dut2 (
        .clk(clk), .rst(rst), .ready(1'b1), .valid(valid2), .cur(cur2),
        .jmp(1'b0), .rel(1'b0), .diff(32'h0), .nxt(32'h0), .call(1'b0), .ret(1'b0),
        .trap(1'b0), .tvec(32'h0), .ras_cnt(cnt2), .ras_uflow(uflow2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic redir(input logic c, input logic r, input logic [31:0] target);
        jmp = 1'b1; call = c; ret = r; rel = 1'b0; nxt = target;
        tick();
        jmp = 1'b0; call = 1'b0; ret = 1'b0;
    endtask

    task automatic st(input string tag, input logic [31:0] pc, input int cnt, input logic uf);
        check({tag, ".cur"}, cur, pc);
        check({tag, ".cnt"}, 32'(ras_cnt), 32'(cnt));
        check({tag, ".uflow"}, 32'(ras_uflow), 32'(uf));
    endtask

    initial begin
        #2;
        check("rst.valid", 32'(valid), 0);
        st("rst", 32'h0, 0, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        check("rel.valid", 32'(valid), 1);
        check("rel.cur", cur, 32'h0);
        check("rel.cur2", cur2, 32'hFFFF_FFF8);
        tick();
        check("seq4", cur, 32'h4);
        check("wrap1", cur2, 32'hFFFF_FFFC);
        tick();
        check("seq8", cur, 32'h8);
        check("wrap2", cur2, 32'h0);
        tick();
        check("seq12", cur, 32'hC);
        tick();
        check("seq16", cur, 32'h10);
        ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall", cur, 32'h10);
        end
        jmp = 1'b1; rel = 1'b1; diff = 32'hFFFF_FFF0;
        tick();
        jmp = 1'b0; rel = 1'b0;
        check("reljmp", cur, 32'h0);
        trap = 1'b1; tvec = 32'h100; jmp = 1'b1; call = 1'b1; nxt = 32'h200;
        tick();
        trap = 1'b0; jmp = 1'b0; call = 1'b0;
        st("trap", 32'h100, 0, 1'b0);
        tick();
        check("trap.hold", cur, 32'h100);
        redir(1'b0, 1'b0, 32'h40);
        st("abs", 32'h40, 0, 1'b0);
        redir(1'b1, 1'b0, 32'h80);
        st("call1", 32'h80, 1, 1'b0);
        redir(1'b1, 1'b0, 32'hC0);
        st("call2", 32'hC0, 2, 1'b0);
        redir(1'b0, 1'b1, 32'h999);
        st("ret1", 32'h84, 1, 1'b0);
        redir(1'b0, 1'b1, 32'h999);
        st("ret2", 32'h44, 0, 1'b0);
        redir(1'b0, 1'b1, 32'h300);
        st("uflow", 32'h300, 0, 1'b1);
        tick();
        st("uflow.end", 32'h300, 0, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            redir(1'b1, 1'b0, 32'(i) << 12);
            check("ovf.cur", cur, 32'(i) << 12);
        end
        check("ovf.cnt", 32'(ras_cnt), 4);
        for (int i = 4; i >= 1; i--) begin
            redir(1'b0, 1'b1, 32'h999);
            st("ovf.pop", (32'(i) << 12) + 32'h4, i - 1, 1'b0);
        end
        redir(1'b0, 1'b1, 32'h600);
        st("ovf.uflow", 32'h600, 0, 1'b1);
        redir(1'b1, 1'b0, 32'h700);
        st("sw.call", 32'h700, 1, 1'b0);
        redir(1'b1, 1'b1, 32'h999);
        st("swap", 32'h604, 1, 1'b0);
        redir(1'b0, 1'b1, 32'h999);
        st("sw.ret", 32'h704, 0, 1'b0);
        ready = 1'b1; call = 1'b1; ret = 1'b1;
        tick();
        call = 1'b0; ret = 1'b0; ready = 1'b0;
        st("nojmp", 32'h708, 0, 1'b0);
        redir(1'b0, 1'b0, 32'h7C);
        redir(1'b1, 1'b0, 32'h10);
        redir(1'b1, 1'b0, 32'h84);
        st("pre.arst", 32'h84, 2, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        check("arst.valid", 32'(valid), 0);
        st("arst", 32'h0, 0, 1'b0);
        #3;
        rst = 1'b1;
        tick();
        check("arst.rel", 32'(valid), 1);
        redir(1'b0, 1'b1, 32'h500);
        st("arst.uflow", 32'h500, 0, 1'b1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
